// File: rtl/mac_rx_pkg.sv
// Shared definitions for the MAC receive sequencer: FSM state encoding,
// the UDP header length and the payload acceptance rule.
package mac_rx_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CHECK   = 4'd1,
        START   = 4'd2,
        WAIT_FD = 4'd3,
        FINISH  = 4'd4,
        ABORT   = 4'd5,
        DROP    = 4'd6,
        RELEASE = 4'd7
    } state_t;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // Payload must be non-empty, within the limit and fit the command FIFO.
    function automatic logic len_ok(input logic [15:0] rx_len,
                                    input logic [15:0] max_payload,
                                    input logic [11:0] free);
        logic [15:0] plen;
        plen = rx_len - UDP_HDR_LEN;
        return (rx_len >= 16'd9) && (plen <= max_payload) && (plen <= {4'h0, free});
    endfunction

endpackage

// File: rtl/mac_rx_stat.sv
// Wrapping packet statistics: copied and rejected/aborted packet counts.
module mac_rx_stat (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_ok,
    input  logic        pkt_drop,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_drop
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ok   <= '0;
            stat_drop <= '0;
        end else begin
            if (pkt_ok)   stat_ok   <= stat_ok + 16'd1;
            if (pkt_drop) stat_drop <= stat_drop + 16'd1;
        end
    end

endmodule

// File: rtl/mac_rx_ctrl.sv
// Receive-side sequencer between the MAC receive buffer and the copy engine.
// Define MAC_RX_CTRL_STAT_EN to add the stat_ok/stat_drop counters.
module mac_rx_ctrl
    import mac_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1024,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rx_done,
    input  logic [15:0] udp_rx_len,
    input  logic [11:0] fifoc_free,
    output logic        fs,
    input  logic        fd,
    output logic        udp_rx_release,
    output logic        pkt_ok,
    output logic        pkt_drop,
    output logic        ovf,
    output logic        busy
`ifdef MAC_RX_CTRL_STAT_EN
    ,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_drop
`endif
);

    localparam logic [15:0] MAX_PL  = 16'(MAX_PAYLOAD);
    localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYC - 1);

    state_t      state, next_state;
    logic        pend;
    logic        pend_clr;
    logic [11:0] wdog;
    logic        wd_expired;
    logic        fd_q;

    assign pend_clr   = (state == IDLE) && pend;
    assign wd_expired = (wdog >= WD_LAST);

    // NOTE: every combinational output gets its default before the case,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pend) next_state = CHECK;
            CHECK:   next_state = len_ok(udp_rx_len, MAX_PL, fifoc_free) ? START : DROP;
            START:   next_state = WAIT_FD;
            WAIT_FD: begin
                if (fd)              next_state = FINISH;
                else if (wd_expired) next_state = ABORT;
            end
            // fd is seen through a register so the copy engine has fully
            // dropped done before the buffer is released.
            FINISH,
            ABORT:   if (!fd_q) next_state = RELEASE;
            DROP:    next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pend           <= 1'b0;
            ovf            <= 1'b0;
            wdog           <= '0;
            fd_q           <= 1'b0;
            fs             <= 1'b0;
            busy           <= 1'b0;
            pkt_ok         <= 1'b0;
            pkt_drop       <= 1'b0;
            udp_rx_release <= 1'b0;
        end else begin
            state <= next_state;
            fd_q  <= fd;
            // A new arrival in the clearing cycle keeps the latch set.
            pend  <= udp_rx_done | (pend & ~pend_clr);
            ovf   <= ovf | (udp_rx_done & pend & ~pend_clr);

            if (state != WAIT_FD)    wdog <= '0;
            else if (wdog != 12'hFFF) wdog <= wdog + 12'd1;

            fs             <= (next_state == WAIT_FD);
            busy           <= (next_state != IDLE);
            pkt_ok         <= (state == WAIT_FD) && (next_state == FINISH);
            pkt_drop       <= (next_state == DROP) ||
                              ((state == WAIT_FD) && (next_state == ABORT));
            udp_rx_release <= (next_state == RELEASE);
        end
    end

`ifdef MAC_RX_CTRL_STAT_EN
    mac_rx_stat u_stat (
        .clk       (clk),
        .rst       (rst),
        .pkt_ok    (pkt_ok),
        .pkt_drop  (pkt_drop),
        .stat_ok   (stat_ok),
        .stat_drop (stat_drop)
    );
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mac_rx_ctrl.sv
// Randomized bench for mac_rx_ctrl against a per-packet timing model.
module tb_mac_rx_ctrl;

    localparam int TB_MAX = 1024;
    localparam int TB_TO  = 16;
    localparam int LIMIT  = 45;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        udp_rx_done = 1'b0;
    logic [15:0] udp_rx_len = '0;
    logic [11:0] fifoc_free = '0;
    logic        fd = 1'b0;
    logic        fs, udp_rx_release, pkt_ok, pkt_drop, ovf, busy;
`ifdef MAC_RX_CTRL_STAT_EN
    logic [15:0] stat_ok, stat_drop;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_ok_cnt = 0;
    int exp_drop_cnt = 0;

    mac_rx_ctrl #(.MAX_PAYLOAD(TB_MAX), .TIMEOUT_CYC(TB_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .udp_rx_done    (udp_rx_done),
        .udp_rx_len     (udp_rx_len),
        .fifoc_free     (fifoc_free),
        .fs             (fs),
        .fd             (fd),
        .udp_rx_release (udp_rx_release),
        .pkt_ok         (pkt_ok),
        .pkt_drop       (pkt_drop),
        .ovf            (ovf),
        .busy           (busy)
`ifdef MAC_RX_CTRL_STAT_EN
        ,
        .stat_ok        (stat_ok),
        .stat_drop      (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_accept(input int len, input int free);
        return (len >= 9) && (len - 8 <= TB_MAX) && (len - 8 <= free);
    endfunction

    // One packet: arrival at cycle 0, copy engine raises fd on cycles [fd_on, fd_off).
    task automatic run_pkt(input int idx, input int len, input int free,
                           input int fd_on, input int fd_off);
        int fs_first = -1, fs_cnt = 0, ok_first = -1, ok_cnt = 0;
        int drop_first = -1, drop_cnt = 0, rel_first = -1, rel_cnt = 0;
        int e_fs_first, e_fs_cnt, e_ok, e_drop, e_rel;
        logic busy2 = 1'b0;
        logic busy_end;
        bit acc;

        udp_rx_len  = 16'(len);
        fifoc_free  = 12'(free);
        udp_rx_done = 1'b1;
        fd          = 1'b0;
        tick();
        udp_rx_done = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            fd = (c >= fd_on) && (c < fd_off);
            if (fs)             begin if (fs_first < 0) fs_first = c; fs_cnt++; end
            if (pkt_ok)         begin if (ok_first < 0) ok_first = c; ok_cnt++; end
            if (pkt_drop)       begin if (drop_first < 0) drop_first = c; drop_cnt++; end
            if (udp_rx_release) begin if (rel_first < 0) rel_first = c; rel_cnt++; end
            if (c == 2) busy2 = busy;
            tick();
        end
        fd = 1'b0;
        busy_end = busy;

        acc = model_accept(len, free);
        if (!acc) begin
            e_fs_first = -1; e_fs_cnt = 0; e_ok = -1; e_drop = 3; e_rel = 4;
            exp_drop_cnt++;
        end else if (fd_on <= 3 + TB_TO) begin
            e_fs_first = 4; e_fs_cnt = fd_on - 3; e_ok = fd_on + 1; e_drop = -1;
            e_rel = fd_off + 2;
            exp_ok_cnt++;
        end else begin
            e_fs_first = 4; e_fs_cnt = TB_TO; e_ok = -1; e_drop = 4 + TB_TO;
            e_rel = 5 + TB_TO;
            exp_drop_cnt++;
        end

        check($sformatf("p%0d fs_first", idx), fs_first, e_fs_first);
        check($sformatf("p%0d fs_cycles", idx), fs_cnt, e_fs_cnt);
        check($sformatf("p%0d ok_cycle", idx), ok_first, e_ok);
        check($sformatf("p%0d ok_pulses", idx), ok_cnt, (e_ok >= 0) ? 1 : 0);
        check($sformatf("p%0d drop_cycle", idx), drop_first, e_drop);
        check($sformatf("p%0d drop_pulses", idx), drop_cnt, (e_drop >= 0) ? 1 : 0);
        check($sformatf("p%0d rel_cycle", idx), rel_first, e_rel);
        check($sformatf("p%0d rel_pulses", idx), rel_cnt, 1);
        check($sformatf("p%0d busy_c2", idx), busy2, 1);
        check($sformatf("p%0d busy_end", idx), busy_end, 0);
        check($sformatf("p%0d ovf", idx), ovf, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int idx = 0;
        int n_drop, n_rel, n_ok;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {fs, busy, udp_rx_release, pkt_ok, pkt_drop, ovf}, 0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Directed cases: nominal, short, space limits, payload limits, timeout, fd-vs-timeout tie.
        run_pkt(idx++, 40,   100,  14,   16);
        run_pkt(idx++, 8,    100,  1000, 1000);
        run_pkt(idx++, 200,  100,  1000, 1000);
        run_pkt(idx++, 200,  192,  9,    12);
        run_pkt(idx++, 9,    1,    4,    5);
        run_pkt(idx++, 1032, 4095, 7,    8);
        run_pkt(idx++, 1033, 4095, 7,    8);
        run_pkt(idx++, 0,    4095, 1000, 1000);
        run_pkt(idx++, 40,   100,  1000, 1000);
        run_pkt(idx++, 40,   100,  3 + TB_TO, 6 + TB_TO);

        for (int i = 0; i < 40; i++) begin
            int len, free, fd_on, fd_off;
            free = $urandom_range(0, 4095);
            case ($urandom_range(0, 3))
                0: len = $urandom_range(0, 16);
                1: len = free + 8 + $urandom_range(0, 6) - 3;
                2: begin free = 4095; len = $urandom_range(1028, 1038); end
                default: len = $urandom_range(0, 65535);
            endcase
            if (len < 0) len = 0;
            if (len > 65535) len = 65535;
            if ($urandom_range(0, 4) == 0) fd_on = 1000;
            else fd_on = 4 + $urandom_range(0, TB_TO - 1);
            fd_off = fd_on + 1 + $urandom_range(0, 4);
            run_pkt(idx++, len, free, fd_on, fd_off);
        end

        // Three arrivals on consecutive cycles: second held pending, third lost.
        udp_rx_len = 16'd4; fifoc_free = 12'd100;
        udp_rx_done = 1'b1; tick();
        tick();
        check("ovf_c2", ovf, 0);
        tick();
        udp_rx_done = 1'b0;
        check("ovf_c3", ovf, 1);
        n_drop = 0; n_rel = 0; n_ok = 0;
        for (int c = 3; c <= 20; c++) begin
            n_drop += int'(pkt_drop);
            n_rel  += int'(udp_rx_release);
            n_ok   += int'(pkt_ok);
            tick();
        end
        exp_drop_cnt += 2;
        check("ovf_drops", n_drop, 2);
        check("ovf_releases", n_rel, 2);
        check("ovf_oks", n_ok, 0);
        check("ovf_sticky", ovf, 1);
        check("ovf_idle", busy, 0);
`ifdef MAC_RX_CTRL_STAT_EN
        check("stat_ok", stat_ok, 16'(exp_ok_cnt));
        check("stat_drop", stat_drop, 16'(exp_drop_cnt));
`endif

        // Reset while the copy engine is running.
        udp_rx_len = 16'd40; fifoc_free = 12'd100;
        udp_rx_done = 1'b1; fd = 1'b0;
        tick();
        udp_rx_done = 1'b0;
        repeat (9) tick();
        check("rst_pre_fs", fs, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_fs", fs, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        n_drop = 0; n_rel = 0; n_ok = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_drop += int'(pkt_drop);
            n_rel  += int'(udp_rx_release);
            n_ok   += int'(pkt_ok) + int'(fs) + int'(busy);
        end
        check("rst_no_release", n_rel, 0);
        check("rst_no_drop", n_drop, 0);
        check("rst_quiet", n_ok, 0);
`ifdef MAC_RX_CTRL_STAT_EN
        check("rst_stat_ok", stat_ok, 0);
        check("rst_stat_drop", stat_drop, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
